// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl: multi-cycle RV32I control FSM sequencing the shared datapath
module riscv_multicycle_ctrl #(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [6:0]       i_opcode,
   input  logic             i_br_cond,
   input  logic             i_mem_ready,
   output logic             o_mem_req,
   output logic             o_mem_we,
   output logic             o_iord,
   output logic             o_ir_write,
   output logic             o_pc_write,
   output logic [1:0]       o_pc_src,
   output logic             o_reg_write,
   output logic [1:0]       o_wb_sel,
   output logic [1:0]       o_alu_src_a,
   output logic [1:0]       o_alu_src_b,
   output logic [1:0]       o_alu_op,
   output logic             o_instr_done,
   output logic [CNT_W-1:0] o_instret,
   output logic             o_halted,
   output logic             o_illegal,
   output logic             o_bus_err
);
   localparam int WT = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR, S_MEM_RD, S_MEM_WR,
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_JALR, S_LUI, S_HALT
   } state_t;
   state_t          r_state, w_next;
   logic            r_run;
   logic [WT-1:0]   r_wait;
   logic [CNT_W-1:0] r_instret;
   logic            r_illegal, r_bus_err;
   logic            w_waiting, w_tmo, w_set_ill, w_set_bus;
   // r_run holds every output low until the first edge after reset release
   assign w_waiting = r_run && (r_state inside {S_FETCH, S_MEM_RD, S_MEM_WR}) && !i_mem_ready;
   assign w_tmo     = (MEM_TIMEOUT != 0) && w_waiting && (r_wait == WT'(MEM_TIMEOUT));
   assign o_instret = r_instret;
   assign o_illegal = r_illegal;
   assign o_bus_err = r_bus_err;
   // next-state and datapath control decode; all outputs default to idle
   always_comb begin
      w_next       = r_state;
      w_set_ill    = 1'b0;
      w_set_bus    = 1'b0;
      o_mem_req    = 1'b0;
      o_mem_we     = 1'b0;
      o_iord       = 1'b0;
      o_ir_write   = 1'b0;
      o_pc_write   = 1'b0;
      o_pc_src     = 2'b00;
      o_reg_write  = 1'b0;
      o_wb_sel     = 2'b00;
      o_alu_src_a  = 2'b00;
      o_alu_src_b  = 2'b00;
      o_alu_op     = 2'b00;
      o_instr_done = 1'b0;
      o_halted     = 1'b0;
      if (r_run) begin
         case (r_state)
            S_FETCH: begin
               o_mem_req   = 1'b1;
               o_alu_src_b = 2'b01;
               if (i_mem_ready) begin
                  o_ir_write = 1'b1;
                  o_pc_write = 1'b1;
                  w_next     = S_DECODE;
               end else if (w_tmo) begin
                  w_set_bus = 1'b1;
                  w_next    = S_HALT;
               end
            end
            S_DECODE: begin
               o_alu_src_a = 2'b11;
               o_alu_src_b = 2'b10;
               case (i_opcode)
                  7'b0110011: w_next = S_EXEC_R;
                  7'b0010011: w_next = S_EXEC_I;
                  7'b0000011: w_next = S_ADDR;
                  7'b0100011: w_next = S_ADDR;
                  7'b1100011: w_next = S_BRANCH;
                  7'b1101111: w_next = S_JAL;
                  7'b1100111: w_next = S_JALR;
                  7'b0110111: w_next = S_LUI;
                  7'b1110011: w_next = S_HALT;
                  default: begin
                     w_set_ill = 1'b1;
                     w_next    = S_HALT;
                  end
               endcase
            end
            S_EXEC_R: begin
               o_alu_src_a = 2'b01;
               o_alu_op    = 2'b10;
               w_next      = S_WB_ALU;
            end
            S_EXEC_I: begin
               o_alu_src_a = 2'b01;
               o_alu_src_b = 2'b10;
               o_alu_op    = 2'b10;
               w_next      = S_WB_ALU;
            end
            S_ADDR: begin
               o_alu_src_a = 2'b01;
               o_alu_src_b = 2'b10;
               w_next      = i_opcode[5] ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
               o_mem_req = 1'b1;
               o_iord    = 1'b1;
               if (i_mem_ready) w_next = S_WB_MEM;
               else if (w_tmo) begin
                  w_set_bus = 1'b1;
                  w_next    = S_HALT;
               end
            end
            S_MEM_WR: begin
               o_mem_req = 1'b1;
               o_mem_we  = 1'b1;
               o_iord    = 1'b1;
               if (i_mem_ready) begin
                  o_instr_done = 1'b1;
                  w_next       = S_FETCH;
               end else if (w_tmo) begin
                  w_set_bus = 1'b1;
                  w_next    = S_HALT;
               end
            end
            S_WB_ALU: begin
               o_reg_write  = 1'b1;
               o_instr_done = 1'b1;
               w_next       = S_FETCH;
            end
            S_WB_MEM: begin
               o_reg_write  = 1'b1;
               o_wb_sel     = 2'b01;
               o_instr_done = 1'b1;
               w_next       = S_FETCH;
            end
            S_BRANCH: begin
               o_alu_src_a  = 2'b01;
               o_alu_op     = 2'b01;
               o_pc_write   = i_br_cond;
               o_pc_src     = 2'b01;
               o_instr_done = 1'b1;
               w_next       = S_FETCH;
            end
            S_JAL: begin
               o_reg_write  = 1'b1;
               o_wb_sel     = 2'b10;
               o_pc_write   = 1'b1;
               o_pc_src     = 2'b01;
               o_instr_done = 1'b1;
               w_next       = S_FETCH;
            end
            S_JALR: begin
               o_alu_src_a  = 2'b01;
               o_alu_src_b  = 2'b10;
               o_reg_write  = 1'b1;
               o_wb_sel     = 2'b10;
               o_pc_write   = 1'b1;
               o_pc_src     = 2'b10;
               o_instr_done = 1'b1;
               w_next       = S_FETCH;
            end
            S_LUI: begin
               o_reg_write  = 1'b1;
               o_wb_sel     = 2'b11;
               o_instr_done = 1'b1;
               w_next       = S_FETCH;
            end
            S_HALT: o_halted = 1'b1;
            default: w_next = S_HALT;
         endcase
      end
   end
   // state register and run-enable
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_FETCH;
         r_run   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_run   <= 1'b1;
      end
   end
   // memory wait counter: counts consecutive not-ready cycles of the current request
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_wait <= '0;
      else          r_wait <= w_waiting ? r_wait + 1'b1 : '0;
   end
   // retired-instruction counter and sticky halt-cause flags
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_instret <= '0;
         r_illegal <= 1'b0;
         r_bus_err <= 1'b0;
      end else begin
         if (o_instr_done) r_instret <= r_instret + 1'b1;
         if (w_set_ill)    r_illegal <= 1'b1;
         if (w_set_bus)    r_bus_err <= 1'b1;
      end
   end
endmodule
